// File: rtl/cache_mem_slave.sv
// Word-addressed 32-bit memory slave with single and incrementing bursts.
// Define CACHE_MEM_SLAVE_WAIT_EN to insert one wait state per command in IDLE.
`ifndef CACHE_AVALON_BURST_COUNT_WIDTH
`define CACHE_AVALON_BURST_COUNT_WIDTH 4
`endif

module cache_mem_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_W    = `CACHE_AVALON_BURST_COUNT_WIDTH
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        s_address,
    input  logic [3:0]         s_byteEnable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [31:0]        s_writeData,
    input  logic               s_beginBurstTransfer,
    input  logic [BURST_W-1:0] s_burstCount,
    output logic               s_waitRequest,
    output logic [31:0]        s_readData,
    output logic               s_readDataValid
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam int         CW       = BURST_W + 1;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  valid_q, valid_d;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] base_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [CW-1:0]         req_cnt;
    logic                  we;
    logic                  accept;
    logic                  wait_idle;
    logic                  unused;

    assign unused   = ^{s_beginBurstTransfer, s_address[31:ADDR_WIDTH+2],
                        s_address[1:0]};
    assign base_idx = s_address[ADDR_WIDTH+1:2];
    assign req_cnt  = (s_burstCount == '0) ? CW'(1) : {1'b0, s_burstCount};

`ifdef CACHE_MEM_SLAVE_WAIT_EN
    // armed_q marks the wait cycle already spent on the pending command
    logic armed_q, armed_d;

    assign armed_d   = (state_q == IDLE) && (s_read || s_write) && !armed_q;
    assign accept    = armed_q;
    assign wait_idle = !armed_q;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    assign accept    = 1'b1;
    assign wait_idle = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        we      = 1'b0;
        wr_idx  = base_idx;
        case (state_q)
            IDLE: begin
                if (accept && s_write) begin
                    we = 1'b1;
                    if (req_cnt > CW'(1)) begin
                        state_d = WR_BURST;
                        addr_d  = base_idx + ADDR_WIDTH'(1);
                        cnt_d   = req_cnt - CW'(1);
                    end
                end else if (accept && s_read) begin
                    rdata_d = mem[base_idx];
                    valid_d = 1'b1;
                    if (req_cnt > CW'(1)) begin
                        state_d = RD_BURST;
                        addr_d  = base_idx + ADDR_WIDTH'(1);
                        cnt_d   = req_cnt - CW'(1);
                    end
                end
            end
            RD_BURST: begin
                rdata_d = mem[addr_q];
                valid_d = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (s_write) begin
                    we     = 1'b1;
                    wr_idx = addr_q;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Array is never reset; a write coinciding with reset is suppressed
    always_ff @(posedge clk) begin
        if (we && !rest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteEnable[b]) begin
                    mem[wr_idx][8*b +: 8] <= s_writeData[8*b +: 8];
                end
            end
        end
    end

    assign s_waitRequest   = (state_q == RD_BURST) ? 1'b1 :
                             (state_q == WR_BURST) ? 1'b0 : wait_idle;
    assign s_readData      = rdata_q;
    assign s_readDataValid = valid_q;

endmodule

// File: tb/tb_cache_mem_slave.sv
// Randomized bench for cache_mem_slave against a beat-level memory model.
// Also honours CACHE_MEM_SLAVE_WAIT_EN when the build defines it.
module tb_cache_mem_slave;

    localparam int AW    = 10;
    localparam int BW    = 4;
    localparam int WORDS = 1 << AW;
`ifdef CACHE_MEM_SLAVE_WAIT_EN
    localparam logic IDLE_WAIT = 1'b1;
`else
    localparam logic IDLE_WAIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rest;
    logic [31:0]   s_address = '0;
    logic [3:0]    s_byteEnable = '0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [31:0]   s_writeData = '0;
    logic          s_beginBurstTransfer = 1'b0;
    logic [BW-1:0] s_burstCount = '0;
    logic          s_waitRequest;
    logic [31:0]   s_readData;
    logic          s_readDataValid;

    cache_mem_slave #(.ADDR_WIDTH(AW), .BURST_W(BW)) dut (
        .clk                 (clk),
        .rest                (rest),
        .s_address           (s_address),
        .s_byteEnable        (s_byteEnable),
        .s_read              (s_read),
        .s_write             (s_write),
        .s_writeData         (s_writeData),
        .s_beginBurstTransfer(s_beginBurstTransfer),
        .s_burstCount        (s_burstCount),
        .s_waitRequest       (s_waitRequest),
        .s_readData          (s_readData),
        .s_readDataValid     (s_readDataValid)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // reference model: memory image plus outstanding beats of the open burst
    logic [31:0] mmem [WORDS];
    int          rd_left, rd_ptr, wr_left, wr_ptr;
    bit          pend;
    bit          m_valid, m_acc;
    logic [31:0] m_rdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_wait();
        if (rd_left > 0) return 1'b1;
        if (wr_left > 0) return 1'b0;
        return IDLE_WAIT ? !pend : 1'b0;
    endfunction

    task automatic model_reset();
        rd_left = 0;
        wr_left = 0;
        pend    = 1'b0;
        m_valid = 1'b0;
        m_acc   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic mwrite(input int i);
        for (int b = 0; b < 4; b++)
            if (s_byteEnable[b]) mmem[i][8*b +: 8] = s_writeData[8*b +: 8];
    endtask

    task automatic model_step();
        int idx;
        int n;
        bit act;
        m_acc   = 1'b0;
        m_valid = 1'b0;
        if (rest) begin
            model_reset();
            return;
        end
        idx = int'(s_address[AW+1:2]);
        n   = (s_burstCount == 0) ? 1 : int'(s_burstCount);
        if (rd_left > 0) begin
            m_rdata = mmem[rd_ptr];
            m_valid = 1'b1;
            rd_ptr  = (rd_ptr + 1) % WORDS;
            rd_left--;
        end else if (wr_left > 0) begin
            if (s_write) begin
                mwrite(wr_ptr);
                wr_ptr = (wr_ptr + 1) % WORDS;
                wr_left--;
            end
        end else begin
            act = s_read || s_write;
            if (IDLE_WAIT) begin
                m_acc = act && pend;
                pend  = act && !pend;
            end else begin
                m_acc = act;
            end
            if (m_acc && s_write) begin
                mwrite(idx);
                wr_left = n - 1;
                wr_ptr  = (idx + 1) % WORDS;
            end else if (m_acc) begin
                m_rdata = mmem[idx];
                m_valid = 1'b1;
                rd_left = n - 1;
                rd_ptr  = (idx + 1) % WORDS;
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("waitRequest", {31'b0, s_waitRequest}, {31'b0, m_wait()});
            chk("readDataValid", {31'b0, s_readDataValid}, {31'b0, m_valid});
            if (m_valid) chk("readData", s_readData, m_rdata);
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int c);
        s_read               = r;
        s_write              = w;
        s_address            = a;
        s_writeData          = d;
        s_byteEnable         = be;
        s_burstCount         = BW'(c);
        s_beginBurstTransfer = 1'($urandom_range(0, 1));
        chk_en               = 1'b1;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic cmd(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int c);
        for (int k = 0; k < 4; k++) begin
            cyc(r, w, a, d, be, c);
            if (m_acc) return;
        end
        nvec++;
        nfail++;
        $display("FAIL cmd_accept: no acceptance within 4 cycles, addr %h", a);
    endtask

    initial begin
        int cnt;
        int guard;
        int kind;
        model_reset();
        rest = 1'b1;
        #3;
        chk("reset_valid", {31'b0, s_readDataValid}, 32'h0);
        chk("reset_rdata", s_readData, 32'h0);
        chk("reset_wait", {31'b0, s_waitRequest}, {31'b0, IDLE_WAIT});
        @(negedge clk);
        rest = 1'b0;

        for (int i = 0; i < WORDS; i++)
            cmd(1'b0, 1'b1, i << 2, $urandom, 4'hF, 1);

`ifdef CACHE_MEM_SLAVE_WAIT_EN
        idle();
        chk("wait_first_cycle", {31'b0, s_waitRequest}, 32'h1);
        cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        chk("wait_not_accepted", {31'b0, s_readDataValid}, 32'h0);
        chk("wait_armed", {31'b0, s_waitRequest}, 32'h0);
        cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        chk("wait_accepted_valid", {31'b0, s_readDataValid}, 32'h1);
        idle();
`endif

        // byte-enable merge then immediate readback
        cmd(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1);
        cmd(1'b0, 1'b1, 32'h10, 32'hA5A5_1234, 4'b0101, 1);
        cmd(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        chk("be_merge_valid", {31'b0, s_readDataValid}, 32'h1);
        chk("be_merge_data", s_readData, 32'hFFA5_FF34);
        idle();

        // wrapping write burst then wrapping read burst
        cmd(1'b0, 1'b1, (WORDS - 2) << 2, 32'hC0DE_03FE, 4'hF, 4);
        cyc(1'b0, 1'b1, 32'h0, 32'hC0DE_03FF, 4'hF, 0);
        cyc(1'b0, 1'b1, 32'h0, 32'hC0DE_0000, 4'hF, 0);
        cyc(1'b0, 1'b1, 32'h0, 32'hC0DE_0001, 4'hF, 0);
        cmd(1'b1, 1'b0, (WORDS - 2) << 2, 32'h0, 4'h0, 4);
        chk("rdwrap_b0", s_readData, 32'hC0DE_03FE);
        chk("rdwrap_wait0", {31'b0, s_waitRequest}, 32'h1);
        idle();
        chk("rdwrap_b1", s_readData, 32'hC0DE_03FF);
        idle();
        chk("rdwrap_b2", s_readData, 32'hC0DE_0000);
        chk("rdwrap_wait2", {31'b0, s_waitRequest}, 32'h1);
        idle();
        chk("rdwrap_b3", s_readData, 32'hC0DE_0001);
        chk("rdwrap_b3_valid", {31'b0, s_readDataValid}, 32'h1);
        idle();
        chk("rdwrap_end_valid", {31'b0, s_readDataValid}, 32'h0);

        // write burst with two stall cycles between beats 1 and 2
        cmd(1'b0, 1'b1, 32'h200, 32'h1111_1111, 4'hF, 3);
        cyc(1'b0, 1'b1, 32'h0, 32'h2222_2222, 4'hF, 0);
        cyc(1'b1, 1'b0, 32'h0, 32'hBAD0_BAD0, 4'hF, 0);
        idle();
        cyc(1'b0, 1'b1, 32'h0, 32'h3333_3333, 4'hF, 0);
        chk("wrburst_idle_wait", {31'b0, s_waitRequest}, {31'b0, IDLE_WAIT});
        cmd(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 3);
        chk("wrburst_rb0", s_readData, 32'h1111_1111);
        idle();
        chk("wrburst_rb1", s_readData, 32'h2222_2222);
        idle();
        chk("wrburst_rb2", s_readData, 32'h3333_3333);

        // count 0 is a single beat; read+write services the write only
        cmd(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("cnt0_data", s_readData, 32'hFFA5_FF34);
        idle();
        chk("cnt0_single", {31'b0, s_readDataValid}, 32'h0);
        cmd(1'b1, 1'b1, 32'h14, 32'h5A5A_5A5A, 4'hF, 1);
        chk("rw_no_valid", {31'b0, s_readDataValid}, 32'h0);
        cmd(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1);
        chk("rw_write_done", s_readData, 32'h5A5A_5A5A);

        // reset aborts an 8-beat read in the middle
        cmd(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1);
        cmd(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 8);
        idle();
        rest = 1'b1;
        model_reset();
        #1;
        chk("abort_valid", {31'b0, s_readDataValid}, 32'h0);
        chk("abort_rdata", s_readData, 32'h0);
        idle();
        rest = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            cnt += int'(s_readDataValid);
        end
        chk("abort_no_beats", cnt, 0);
        cmd(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
        chk("abort_next_cmd", s_readData, 32'hDEAD_BEEF);

        // longest burst completes with exactly 15 beats
        cmd(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 15);
        cnt = int'(s_readDataValid);
        for (int k = 0; k < 20; k++) begin
            idle();
            cnt += int'(s_readDataValid);
        end
        chk("max_burst_beats", cnt, 15);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            cmd(kind < 5, kind >= 4, $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 15));
            guard = 0;
            while ((rd_left > 0 || wr_left > 0) && guard < 64) begin
                guard++;
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    $urandom, $urandom, 4'($urandom), $urandom_range(0, 15));
            end
            if (guard >= 64) begin
                nvec++;
                nfail++;
                $display("FAIL burst_drain: burst did not finish in 64 cycles");
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
